// File: rtl/vedic_pp_combiner.sv
// Elastic 3-stage combiner turning the four HxH Urdhva-Tiryakbhyam sub-products into the 4H-bit product.
// Also holds carray_select_adder, the operand + carry_in carry-select adder used for the final increment.

module carray_select_adder #(
  parameter int ADDER_WIDTH = 32,
  parameter int BLOCK_WIDTH = 8
) (
  input  logic [ADDER_WIDTH-1:0] operand,
  input  logic                   carry_in,
  output logic [ADDER_WIDTH-1:0] sum
);

  localparam int NUM_BLOCKS = (ADDER_WIDTH + BLOCK_WIDTH - 1) / BLOCK_WIDTH;

  // c[i] is the carry entering block i; each block precomputes its cin=0/cin=1 result and muxes
  logic [NUM_BLOCKS-1:0] c;
  assign c[0] = carry_in;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
    localparam int LO = i * BLOCK_WIDTH;
    localparam int BW = (i == NUM_BLOCKS - 1) ? ADDER_WIDTH - LO : BLOCK_WIDTH;

    if (i < NUM_BLOCKS - 1) begin : g_mid
      logic [BW:0] inc;
      assign inc          = {1'b0, operand[LO +: BW]} + {{BW{1'b0}}, 1'b1};
      assign sum[LO +: BW] = c[i] ? inc[BW-1:0] : operand[LO +: BW];
      assign c[i+1]       = c[i] & inc[BW];
    end else begin : g_last
      // Carry out of the top block is never needed by the combiner
      assign sum[LO +: BW] = c[i] ? operand[LO +: BW] + {{(BW-1){1'b0}}, 1'b1}
                                  : operand[LO +: BW];
    end
  end

endmodule

module vedic_pp_combiner #(
  parameter int HALF_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*HALF_WIDTH-1:0]   pp_ll,
  input  logic [2*HALF_WIDTH-1:0]   pp_lh,
  input  logic [2*HALF_WIDTH-1:0]   pp_hl,
  input  logic [2*HALF_WIDTH-1:0]   pp_hh,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*HALF_WIDTH-1:0]   out_product,
  output logic                      busy
);

  localparam int H  = HALF_WIDTH;
  localparam int W2 = 2 * HALF_WIDTH;

  logic          s1_valid, s2_valid;
  logic [W2-1:0] s1_ll, s1_hh;
  logic [W2:0]   s1_mid;
  logic [W2-1:0] s2_low, s2_up;
  logic          s2_c2;

  logic          s1_free, s2_free, s3_free;
  logic [W2:0]   low_sum;
  logic [W2-1:0] up_pre;
  logic [W2-1:0] upper;

  // A stage frees when it is empty or the stage after it is taking its contents this cycle
  always_comb begin
    s3_free  = !out_valid || out_ready;
    s2_free  = !s2_valid || s3_free;
    s1_free  = !s1_valid || s2_free;
    in_ready = !rst && s1_free;
    busy     = s1_valid | s2_valid | out_valid;
  end

  // Low half of mid lands on top of pp_ll; its high H+1 bits fold into pp_hh
  always_comb begin
    low_sum = {1'b0, s1_ll} + {1'b0, s1_mid[H-1:0], {H{1'b0}}};
    up_pre  = s1_hh + W2'(s1_mid[W2:H]);
  end

  carray_select_adder #(.ADDER_WIDTH(W2)) u_final_inc (
    .operand  (s2_up),
    .carry_in (s2_c2),
    .sum      (upper)
  );

  // NOTE: every state element uses non-blocking assignment so all stages shift off the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_ll       <= '0;
      s1_hh       <= '0;
      s1_mid      <= '0;
      s2_valid    <= 1'b0;
      s2_low      <= '0;
      s2_up       <= '0;
      s2_c2       <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else begin
      if (s1_free) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_ll  <= pp_ll;
          s1_hh  <= pp_hh;
          s1_mid <= {1'b0, pp_lh} + {1'b0, pp_hl};
        end
      end
      if (s2_free) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_low <= low_sum[W2-1:0];
          s2_c2  <= low_sum[W2];
          s2_up  <= up_pre;
        end
      end
      if (s3_free) begin
        out_valid <= s2_valid;
        if (s2_valid) out_product <= {upper, s2_low};
      end
    end
  end

endmodule

// File: tb/tb_vedic_pp_combiner.sv
// Scoreboard bench for vedic_pp_combiner: directed corner cases plus random a*b traffic
// with random backpressure, checked against plain 64-bit arithmetic.

module tb_vedic_pp_combiner;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_accept_cyc = 0;
  bit rnd_ready  = 0;
  logic [63:0] exp_q[$];

  vedic_pp_combiner #(.HALF_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pp_ll       (pp_ll),
    .pp_lh       (pp_lh),
    .pp_hl       (pp_hl),
    .pp_hh       (pp_hh),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_combine(input logic [31:0] ll, lh, hl, hh);
    return 64'(ll) + ((64'(lh) + 64'(hl)) << 16) + (64'(hh) << 32);
  endfunction

  // Present one set and hold it until accepted; the expectation is queued once acceptance is certain
  task automatic send(input logic [31:0] ll, lh, hl, hh, input logic [63:0] exp);
    bit done = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    pp_ll = ll; pp_lh = lh; pp_hl = hl; pp_hh = hh;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        last_accept_cyc = cyc;
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("drain_busy", busy, 1'b0);
  endtask

  task automatic send_ab(input logic [31:0] a, b);
    send(a[15:0] * b[15:0], a[15:0] * b[31:16], a[31:16] * b[15:0], a[31:16] * b[31:16],
         64'(a) * 64'(b));
  endtask

  // Monitor: pops on every output transfer, and holds the DUT to a stable product while stalled
  initial begin
    bit          prev_stall = 0;
    logic [63:0] prev_prod  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else if (out_valid) begin
        if (prev_stall) check("stall_hold", out_product, prev_prod);
        if (out_ready) begin
          check("no_x", 64'($isunknown(out_product)), 64'd0);
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_output: got %h, expected nothing (cycle %0d)", out_product, cyc);
          end else begin
            check("product", out_product, exp_q.pop_front());
          end
        end
        prev_stall = !out_ready;
        prev_prod  = out_product;
      end else begin
        if (prev_stall) check("stall_valid_drop", out_valid, 1'b1);
        prev_stall = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [63:0] first_exp;
    int          run;
    bit          seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    pp_ll = '0; pp_lh = '0; pp_hl = '0; pp_hh = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_product", out_product, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1'b1);

    // All-ones sub-products, with latency measured from the accepting cycle
    send(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 64'hFFFFFFFE00000001);
    idle(1);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (out_valid) seen = 1; else @(negedge clk);
    end
    check("latency", 64'(cyc - last_accept_cyc), 64'd3);
    drain();

    // Carry out of the low half into the upper half
    send(32'hFFFE0001, 32'h0000FFFF, 32'h0, 32'h0, 64'h00000001FFFD0001);
    idle(1);
    drain();

    // Backpressure: three fill the pipe, the fourth waits until the output pops
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h1111 * (i + 1), 32'hABCD0000 + i, 32'h00001234, 32'h80000000 >> i,
                                     ref_combine(32'h1111 * (i + 1), 32'hABCD0000 + i, 32'h00001234, 32'h80000000 >> i));
    first_exp = exp_q[0];
    @(posedge clk); #1;
    pp_ll = 32'hDEADBEEF; pp_lh = 32'hCAFEF00D; pp_hl = 32'h0BADC0DE; pp_hh = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_product", out_product, first_exp);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1'b1);
    exp_q.push_back(ref_combine(32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678));
    idle(1);
    drain();

    // Streaming: eight sets back to back must emerge on eight consecutive cycles
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [31:0] a, b;
          a = $urandom; b = $urandom;
          send_ab(a, b);
        end
        idle(1);
      end
      begin
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          if (out_valid) seen = 1;
        end
        run = 0;
        for (int k = 0; k < 8; k++) begin
          if (out_valid) run++;
          @(negedge clk);
        end
        check("stream_run", 64'(run), 64'd8);
      end
    join
    drain();

    // Reset with two sets in flight: nothing from before the reset may ever surface
    send_ab(32'h12345678, 32'h9ABCDEF0);
    send_ab(32'hFFFFFFFF, 32'h00000003);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready_low", in_ready, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_product", out_product, 64'd0);
    check("rst_in_ready_high", in_ready, 1'b1);
    idle(6);

    // Random operands, random input gaps, random output backpressure
    rnd_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (i % 50 == 0) begin
        a = (i % 100 == 0) ? 32'hFFFFFFFF : 32'h0;
        b = 32'hFFFFFFFF;
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_ab(a, b);
    end
    idle(1);
    @(posedge clk); #1;
    rnd_ready = 0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
